// File: rtl/regfile_sb_if.sv
// Decode/WB-facing bundle for the integer register file: write-back,
// two read ports, issue marking, and the scoreboard status outputs.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_waddr;
  logic              busy1;
  logic              busy2;
  logic              sb_err;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2, issue_valid, issue_waddr,
    input  rdata1, rdata2, busy1, busy2, sb_err
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2, issue_valid, issue_waddr,
    output rdata1, rdata2, busy1, busy2, sb_err
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with WB bypass and a per-register pending-write
// scoreboard that drives decode's stall/forward decision.
module regfile_sb_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              rst_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rval_i,
  input  logic [CNT_W-1:0]  cnt_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o
);
  logic hit, wb_match;

  assign hit      = !rst_i && re_i && (raddr_i != '0);
  assign wb_match = we_i && (waddr_i == raddr_i);

  assign rdata_o = !hit     ? '0      :
                   wb_match ? wdata_i : rval_i;

  // The last outstanding write committing now is already forwarded.
  assign busy_o = hit && (cnt_i != '0) &&
                  !(wb_match && (cnt_i == CNT_W'(1)));
endmodule

module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic clk,
  input  logic rst,
  regfile_sb_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NREG-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [NREG-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic                        err_q, err_d;

  logic wr_en, iss_en, same_reg;

  assign wr_en    = bus.we && (bus.waddr != '0);
  assign iss_en   = bus.issue_valid && (bus.issue_waddr != '0);
  assign same_reg = wr_en && iss_en && (bus.waddr == bus.issue_waddr);

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (wr_en) mem_d[bus.waddr] = bus.wdata;
    // Issue and commit on one register cancel out.
    if (!same_reg) begin
      if (iss_en) begin
        if (cnt_q[bus.issue_waddr] == CNT_MAX) err_d = 1'b1;
        else cnt_d[bus.issue_waddr] = cnt_q[bus.issue_waddr] + 1'b1;
      end
      if (wr_en) begin
        if (cnt_q[bus.waddr] == '0) err_d = 1'b1;
        else cnt_d[bus.waddr] = cnt_q[bus.waddr] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  logic [1:0]             rd_re;
  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] rd_data;
  logic [1:0]             rd_busy;

  assign rd_re   = {bus.re2, bus.re1};
  assign rd_addr = {bus.raddr2, bus.raddr1};

  for (genvar g = 0; g < 2; g++) begin : g_rd
    regfile_sb_rdport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) u_rd (
      .rst_i   (rst),
      .re_i    (rd_re[g]),
      .raddr_i (rd_addr[g]),
      .we_i    (bus.we),
      .waddr_i (bus.waddr),
      .wdata_i (bus.wdata),
      .rval_i  (mem_q[rd_addr[g]]),
      .cnt_i   (cnt_q[rd_addr[g]]),
      .rdata_o (rd_data[g]),
      .busy_o  (rd_busy[g])
    );
  end

  assign bus.rdata1 = rd_data[0];
  assign bus.rdata2 = rd_data[1];
  assign bus.busy1  = rd_busy[0];
  assign bus.busy2  = rd_busy[1];
  assign bus.sb_err = err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: per-cycle check against a behavioural
// register/scoreboard model plus hand-computed spot checks.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_mem [32];
  int            m_cnt [32];
  bit            m_err;
  bit            chk_on = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input bit re, input logic [AW-1:0] a);
    if (rst || !re || a == 0) return '0;
    if (bus.we && bus.waddr == a) return bus.wdata;
    return m_mem[a];
  endfunction

  function automatic logic [DW-1:0] exp_busy(input bit re, input logic [AW-1:0] a);
    if (rst || !re || a == 0) return '0;
    if (m_cnt[a] == 0) return '0;
    if (bus.we && bus.waddr == a && m_cnt[a] == 1) return '0;
    return 32'd1;
  endfunction

  // Check outputs, then advance the model to the state after the next edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("rdata1", bus.rdata1, exp_rd(bus.re1, bus.raddr1));
      chk("rdata2", bus.rdata2, exp_rd(bus.re2, bus.raddr2));
      chk("busy1", {31'b0, bus.busy1}, exp_busy(bus.re1, bus.raddr1));
      chk("busy2", {31'b0, bus.busy2}, exp_busy(bus.re2, bus.raddr2));
      chk("sb_err", {31'b0, bus.sb_err}, {31'b0, m_err});
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_cnt[i] = 0; end
      m_err = 1'b0;
    end else begin
      automatic bit inc = bus.issue_valid && bus.issue_waddr != 0;
      automatic bit dec = bus.we && bus.waddr != 0;
      if (dec) m_mem[bus.waddr] = bus.wdata;
      if (!(inc && dec && bus.issue_waddr == bus.waddr)) begin
        if (inc) begin
          if (m_cnt[bus.issue_waddr] == 3) m_err = 1'b1;
          else m_cnt[bus.issue_waddr]++;
        end
        if (dec) begin
          if (m_cnt[bus.waddr] == 0) m_err = 1'b1;
          else m_cnt[bus.waddr]--;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.we = 0; bus.waddr = '0; bus.wdata = '0;
    bus.re1 = 0; bus.raddr1 = '0; bus.re2 = 0; bus.raddr2 = '0;
    bus.issue_valid = 0; bus.issue_waddr = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_cnt[i] = 0; end
    m_err = 1'b0;
    clr();
    rst = 1;
    step();
    chk_on = 1;
    step();
    rst = 0;

    // 1: post-reset read
    bus.re1 = 1; bus.raddr1 = 5;
    @(negedge clk);
    chk("t1_rdata1", bus.rdata1, 32'h0);
    chk("t1_busy1", {31'b0, bus.busy1}, 32'h0);
    chk("t1_sb_err", {31'b0, bus.sb_err}, 32'h0);
    step();

    // 2: write, bypass, then storage read
    bus.we = 1; bus.waddr = 5; bus.wdata = 32'hDEADBEEF;
    bus.re2 = 1; bus.raddr2 = 5;
    @(negedge clk);
    chk("t2_bypass", bus.rdata2, 32'hDEADBEEF);
    step();
    bus.we = 0; bus.wdata = '0;
    @(negedge clk);
    chk("t2_stored", bus.rdata1, 32'hDEADBEEF);
    step();

    // 3: x0 write/issue are ignored
    clr();
    bus.we = 1; bus.waddr = 0; bus.wdata = 32'h12345678;
    step();
    bus.we = 0;
    bus.re1 = 1; bus.raddr1 = 0;
    bus.issue_valid = 1; bus.issue_waddr = 0;
    @(negedge clk);
    chk("t3_x0_rd", bus.rdata1, 32'h0);
    step();
    bus.issue_valid = 0;
    @(negedge clk);
    chk("t3_x0_busy", {31'b0, bus.busy1}, 32'h0);
    step();

    // 4: scoreboard life cycle on x7
    clr();
    bus.re1 = 1; bus.raddr1 = 7;
    bus.issue_valid = 1; bus.issue_waddr = 7;
    step();
    @(negedge clk);
    chk("t4_busy_c2", {31'b0, bus.busy1}, 32'h1);
    step();
    bus.we = 1; bus.waddr = 7; bus.wdata = 32'hA1;
    @(negedge clk);
    chk("t4_busy_c3", {31'b0, bus.busy1}, 32'h1);
    step();
    bus.issue_valid = 0; bus.wdata = 32'hA2;
    @(negedge clk);
    chk("t4_busy_c4", {31'b0, bus.busy1}, 32'h1);
    step();
    bus.wdata = 32'hA3;
    @(negedge clk);
    chk("t4_busy_c5", {31'b0, bus.busy1}, 32'h0);
    chk("t4_byp_c5", bus.rdata1, 32'hA3);
    step();
    bus.we = 0; bus.wdata = '0;
    @(negedge clk);
    chk("t4_busy_c6", {31'b0, bus.busy1}, 32'h0);
    chk("t4_data_c6", bus.rdata1, 32'hA3);
    step();

    // 5: overflow on x9, then underflow on x3
    clr();
    bus.re1 = 1; bus.raddr1 = 9;
    bus.issue_valid = 1; bus.issue_waddr = 9;
    repeat (4) step();
    bus.issue_valid = 0;
    @(negedge clk);
    chk("t5_ovf_busy", {31'b0, bus.busy1}, 32'h1);
    chk("t5_ovf_err", {31'b0, bus.sb_err}, 32'h1);
    bus.we = 1; bus.waddr = 9; bus.wdata = 32'h99;
    step();
    step();
    bus.we = 0;
    @(negedge clk);
    chk("t5_sat_cnt", {31'b0, bus.busy1}, 32'h1);
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("t5_rst_err", {31'b0, bus.sb_err}, 32'h0);
    chk("t5_rst_busy", {31'b0, bus.busy1}, 32'h0);
    bus.we = 1; bus.waddr = 3; bus.wdata = 32'h33;
    step();
    bus.we = 0;
    @(negedge clk);
    chk("t5_unf_err", {31'b0, bus.sb_err}, 32'h1);
    step();
    rst = 1;
    step();
    rst = 0;

    // 6: pending state discarded by reset
    clr();
    bus.re1 = 1; bus.raddr1 = 4;
    bus.issue_valid = 1; bus.issue_waddr = 4;
    step();
    bus.we = 1; bus.waddr = 4; bus.wdata = 32'h55;
    step();
    bus.we = 0; bus.issue_valid = 0; bus.wdata = '0;
    @(negedge clk);
    chk("t6_pre_data", bus.rdata1, 32'h55);
    chk("t6_pre_busy", {31'b0, bus.busy1}, 32'h1);
    step();
    rst = 1;
    @(negedge clk);
    chk("t6_in_rst", bus.rdata1, 32'h0);
    step();
    rst = 0;
    @(negedge clk);
    chk("t6_data", bus.rdata1, 32'h0);
    chk("t6_busy", {31'b0, bus.busy1}, 32'h0);
    chk("t6_err", {31'b0, bus.sb_err}, 32'h0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
